mem_read_streamer: RTL
======================

// Module: mem_read_streamer
// PURPOSE
//   Read-side DMA stage placed directly downstream of the shared dual-port memory.
//   Accepts a (base, length) command and drives one memory port's address
//   and write-enable. Absorbs the memory's 1-cycle registered read latency in
//   a 2-entry FIFO and emits the words as a valid/ready stream for the compute
//   datapath. Sustains 1 word/cycle while the consumer holds out_ready high.
// PARAMETERS
//   DATA  72  word width; matches the memory's data width
//   ADDR  10  address width; memory depth is 2**ADDR words
// PORTS
//   clk         in   1       single clock; all state updates on posedge
//   rst_n       in   1       asynchronous, active-low reset
//   cmd_valid   in   1       command present
//   cmd_ready   out  1       block idle, command accepted on valid&&ready
//   cmd_base    in   ADDR    first word address
//   cmd_len     in   ADDR+1  word count, 0..2**ADDR
//   mem_addr    out  ADDR    address to the memory port
//   mem_wr      out  1       memory port write enable, tied 0
//   mem_din     out  DATA    memory port write data, tied 0
//   mem_dout    in   DATA    memory port read data, valid 1 cycle after mem_addr
//   out_valid   out  1       stream word available
//   out_ready   in   1       consumer accepts word
//   out_data    out  DATA    stream word
//   out_last    out  1       qualifies the final word of the command
//   busy        out  1       state != IDLE
//   done        out  1       1-cycle pulse when the command completes
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     - state=IDLE; FIFO and pending flag cleared; counters cleared.
//     - Outputs: cmd_ready=1, out_valid=0, out_last=0, done=0, busy=0, mem_addr=0.
//     - Reset mid-transfer abandons the command and discards any in-flight read.
//   States:
//     - IDLE: cmd_ready=1. On accept, latch base/len and go to RUN.
//       cmd_len > 2**ADDR is clamped to 2**ADDR.
//     - RUN: issue reads. Once all reads are issued, go to DRAIN.
//     - DRAIN: wait until pending=0 and the FIFO is empty, then go to IDLE.
//     - len=0: go straight to DRAIN; done pulses 2 cycles after accept; no beats are emitted.
//   Read issue:
//     - In RUN, mem_addr = rd_ptr.
//     - A read issues in a cycle when rem>0 && (fifo_cnt + pending - pop) < 2,
//       where pop = out_valid && out_ready.
//     - On issue: rd_ptr+1 (wraps mod 2**ADDR), rem-1, pending<=1.
//     - If pending=1, mem_dout is pushed into the FIFO at the next edge.
//     - The FIFO never overflows; an overflow is a design error (assertion).
//   Timing:
//     - Accept at edge T -> mem_addr=base during T+1 -> word in FIFO after edge T+2
//       -> out_valid=1 in cycle T+2+1.
//     - With out_ready=1 constantly, words are contiguous: one per cycle.
//   Stream rules:
//     - out_data and out_last hold stable while out_valid && !out_ready.
//     - out_valid never drops without a handshake.
//     - out_last=1 only on the word whose index is len-1.
//   Completion:
//     - The handshake of the last word moves the block to IDLE at that edge.
//     - done=1 for exactly the next cycle; cmd_ready=1 in that same cycle.
//     - A new command accepted in the done cycle is legal (back-to-back).
//   mem_wr and mem_din are constant 0; this block never writes.
// TESTING
//   - Reset: pulse rst_n low mid-RUN (base=0x010, len=8) -> out_valid=0 and
//     cmd_ready=1 asynchronously; no stale word appears after release.
//   - Streaming: preload mem[0x100+i]=i; cmd base=0x100, len=16, out_ready=1 ->
//     16 contiguous beats 0..15, first at accept+3, out_last on 15, done next cycle.
//   - Backpressure: same preload, out_ready random 50% -> same ordered data, no loss
//     or duplication; data stable while stalled; mem_addr never >2 ahead of consumer.
//   - Wrap: base=0x3FE, len=4 -> reads 0x3FE,0x3FF,0x000,0x001 in order.
//   - Edges: len=0 -> no beats, done 2 cycles after accept. len=1024 -> full sweep,
//     1024 beats. len=2000 -> clamped to 1024.
//   - Back-to-back: second cmd (base=0x200, len=2) held valid during first ->
//     accepted in the done cycle, beats follow with no overlap.

Source files
------------

// File: rtl/mem_read_streamer_if.sv
// ----------------------------------------------------------------------------
// mem_read_streamer_if
//   Bundles the command, memory-port and output-stream signals of the read
//   streamer.
//
//   Signal groups
//     command : cmd_valid, cmd_ready, cmd_base, cmd_len
//     memory  : mem_addr, mem_wr, mem_din, mem_dout (registered read, 1 cycle)
//     stream  : out_valid, out_ready, out_data, out_last
//     status  : busy, done
//
//   Modports
//     master : the streamer itself (drives memory address and the stream)
//     slave  : the surroundings (command source, memory, stream consumer)
// ----------------------------------------------------------------------------
interface mem_read_streamer_if #(
    parameter int DATA = 72,
    parameter int ADDR = 10
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [ADDR-1:0] cmd_base;
    logic [ADDR:0]   cmd_len;

    logic [ADDR-1:0] mem_addr;
    logic            mem_wr;
    logic [DATA-1:0] mem_din;
    logic [DATA-1:0] mem_dout;

    logic            out_valid;
    logic            out_ready;
    logic [DATA-1:0] out_data;
    logic            out_last;

    logic            busy;
    logic            done;

    modport master (
        input  cmd_valid, cmd_base, cmd_len, mem_dout, out_ready,
        output cmd_ready, mem_addr, mem_wr, mem_din,
               out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_len, mem_dout, out_ready,
        input  cmd_ready, mem_addr, mem_wr, mem_din,
               out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/mem_read_streamer.sv
// ----------------------------------------------------------------------------
// mem_read_streamer
//   Read-side DMA stage sitting right after a dual-port memory. A (base, len)
//   command walks len consecutive addresses (wrapping at 2**ADDR) on one
//   memory port. The memory's 1-cycle registered read latency is absorbed by
//   a 2-entry FIFO, so words leave as a valid/ready stream at one word per
//   cycle while the consumer keeps out_ready high.
//
//   Ports
//     clk    : single clock, all state on posedge
//     rst_n  : asynchronous active-low reset; abandons any command in flight
//     bus    : mem_read_streamer_if.master
//              cmd_*  command handshake (accepted on cmd_valid && cmd_ready)
//              mem_*  memory port (read only: mem_wr/mem_din tied to 0)
//              out_*  output stream, out_last marks the final word
//              busy   high whenever not idle
//              done   1-cycle pulse after the last word's handshake
// ----------------------------------------------------------------------------
module mem_read_streamer #(
    parameter int DATA = 72,
    parameter int ADDR = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_read_streamer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR:0]   MAX_LEN = {1'b1, {ADDR{1'b0}}};
    localparam logic [ADDR:0]   ONE_LEN = {{ADDR{1'b0}}, 1'b1};
    localparam logic [ADDR-1:0] ONE_PTR = {{(ADDR-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_next;

    logic [ADDR-1:0] r_rd_ptr;        // next address to read
    logic [ADDR:0]   r_rem;           // reads still to issue
    logic            r_pending;       // a read was issued last cycle
    logic            r_pending_last;  // ...and it was the command's final word

    logic [DATA-1:0] r_fifo_data [2];
    logic [1:0]      r_fifo_last;
    logic            r_wr_idx;
    logic            r_rd_idx;
    logic [1:0]      r_cnt;

    logic            r_done;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic            w_cmd_ready;
    logic            w_busy;
    logic            w_accept;
    logic            w_out_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic            w_issue_last;
    logic            w_drained;
    logic [ADDR:0]   w_len;
    logic [2:0]      w_occ;

    assign w_out_valid  = (r_cnt != 2'd0);
    assign w_pop        = w_out_valid && bus.out_ready;
    assign w_push       = r_pending;
    assign w_accept     = bus.cmd_valid && w_cmd_ready;
    assign w_len        = (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;

    // Slots that will be occupied after this edge if no new read issues.
    // Counting the in-flight read and crediting this cycle's pop lets the
    // pipe run at full rate with only two FIFO entries.
    assign w_occ        = {1'b0, r_cnt} + {2'b00, r_pending} - {2'b00, w_pop};
    assign w_issue      = (r_state == S_RUN) && (r_rem != '0) && (w_occ < 3'd2);
    assign w_issue_last = w_issue && (r_rem == ONE_LEN);

    // Nothing in flight and the FIFO is empty, or its sole word leaves now.
    assign w_drained    = !r_pending &&
                          ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                // A zero-length command still passes through DRAIN so done
                // keeps its usual timing relative to the accept.
                if (w_accept) begin
                    w_next = (w_len == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (w_issue_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_cmd_ready = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                w_busy      = 1'b0;
            end
            default: begin
                w_cmd_ready = 1'b0;
                w_busy      = 1'b1;
            end
        endcase
    end

    // done follows the DRAIN->IDLE edge, so it coincides with cmd_ready=1
    // and a queued command can be taken in that same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_DRAIN) && (w_next == S_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Read issue
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr       <= '0;
            r_rem          <= '0;
            r_pending      <= 1'b0;
            r_pending_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rd_ptr <= bus.cmd_base;
                r_rem    <= w_len;
            end else if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + ONE_PTR;  // wraps at 2**ADDR
                r_rem    <= r_rem - ONE_LEN;
            end
            r_pending      <= w_issue;
            r_pending_last <= w_issue_last;
        end
    end

    // ------------------------------------------------------------------
    // 2-entry FIFO; the last flag travels with each word
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= '0;
            r_wr_idx       <= 1'b0;
            r_rd_idx       <= 1'b0;
            r_cnt          <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_idx] <= bus.mem_dout;
                r_fifo_last[r_wr_idx] <= r_pending_last;
                r_wr_idx              <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // The issue throttle guarantees a free slot for every returning read.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_cnt == 2'd2)));

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign bus.cmd_ready = w_cmd_ready;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.mem_addr  = r_rd_ptr;
    assign bus.mem_wr    = 1'b0;
    assign bus.mem_din   = '0;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_fifo_data[r_rd_idx];
    assign bus.out_last  = w_out_valid && r_fifo_last[r_rd_idx];

endmodule
